// File: rtl/n13_array_corr_scheduler.sv
// n13_array_corr_scheduler
//  Sequential multi-error corrector for a 5x5 block of AN-coded (A=13) 6-bit
//  codewords. One block is accepted per in_valid/in_ready handshake. All 25
//  cells are split into quotient/residue in one cycle. A single shared decoder
//  then visits every cell, one per cycle, for a fixed 25 cycles. That visit
//  corrects each flagged cell, unless the block has more than MAX_CORR flags.
//
//  Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_codewords    150 bits, cell i at [6i+5:6i], i = row*5 + col
//   in_valid        block present on in_codewords
//   in_ready        high only while idle
//   out_msg         75 bits, cell i message at [3i+2:3i]
//   out_err_mask    per-cell residue-nonzero flag
//   out_err_count   popcount of out_err_mask
//   out_uncorr      block had more than MAX_CORR flags, raw quotients emitted
//   out_valid       result valid, held until out_ready
//   out_ready       sink accepts result
module n13_array_corr_scheduler #(
  parameter int ROWS     = 5,
  parameter int COLS     = 5,
  parameter int MAX_CORR = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [149:0] in_codewords,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [74:0]  out_msg,
  output logic [24:0]  out_err_mask,
  output logic [4:0]   out_err_count,
  output logic         out_uncorr,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int CELLS = ROWS * COLS;

  typedef enum logic [1:0] {IDLE, CALC, CORR, DONE} state_t;

  // Barrett split of a 6-bit word by 13: {err, r[3:0], q[2:0]}.
  // 19/256 underestimates 1/13 by less than one quotient step over 0..63,
  // so a single conditional correction is enough.
  function automatic logic [7:0] barrett_n13(input logic [5:0] cw);
    logic [10:0] prod;
    logic [2:0]  q;
    logic [6:0]  rem;
    prod = {5'd0, cw} * 11'd19;
    q    = prod[10:8];
    rem  = {1'b0, cw} - (7'd13 * {4'd0, q});
    if (rem >= 7'd13) begin
      q   = q + 3'd1;
      rem = rem - 7'd13;
    end else begin
      q   = q;
    end
    return {(rem != 7'd0), rem[3:0], q};
  endfunction

  // Single-bit AN decoder: rebuild the codeword from q/r and find the one
  // bit flip that lands on a multiple of 13. Syndromes +/-2^j mod 13 are all
  // distinct for j=0..5, so at most one flip matches. No match keeps q.
  function automatic logic [2:0] an_decoder_n13(input logic [2:0] q, input logic [3:0] r);
    logic [6:0] cw;
    logic [6:0] flip;
    logic [2:0] msg;
    msg = q;
    cw  = (7'd13 * {4'd0, q}) + {3'd0, r};
    for (int j = 0; j < 6; j++) begin
      flip = cw ^ (7'd1 << j);
      if ((flip % 7'd13) == 7'd0) begin
        msg = 3'(flip / 7'd13);
      end else begin
        msg = msg;
      end
    end
    return msg;
  endfunction

  state_t state, state_nx;

  logic [CELLS-1:0][5:0] cw_reg;
  logic [CELLS-1:0][2:0] q_reg;
  logic [CELLS-1:0][3:0] r_reg;
  logic [CELLS-1:0]      err_reg;
  logic [4:0]            cnt;
  logic                  uncorr;
  logic [4:0]            idx;

  logic [CELLS-1:0][7:0] calc_s;
  logic [4:0]            pop_s;
  logic [2:0]            dec_msg_s;
  logic [CELLS-1:0][2:0] q_upd_s;

  assign in_ready = (state == IDLE) && !rst;

  // Barrett split of every latched cell plus the flag popcount.
  always_comb begin
    pop_s = 5'd0;
    for (int i = 0; i < CELLS; i++) begin
      calc_s[i] = barrett_n13(cw_reg[i]);
      pop_s     = pop_s + {4'd0, calc_s[i][7]};
    end
  end

  // Shared decoder on the cell under idx; result replaces q only when flagged.
  always_comb begin
    dec_msg_s = an_decoder_n13(q_reg[idx], r_reg[idx]);
    q_upd_s   = q_reg;
    if (err_reg[idx] && !uncorr) begin
      q_upd_s[idx] = dec_msg_s;
    end else begin
      q_upd_s[idx] = q_reg[idx];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = CALC; else state_nx = IDLE;
      CALC:    state_nx = CORR;
      CORR:    if (idx == 5'(CELLS - 1)) state_nx = DONE; else state_nx = CORR;
      DONE:    if (out_ready) state_nx = IDLE; else state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_reg        <= '0;
      q_reg         <= '0;
      r_reg         <= '0;
      err_reg       <= '0;
      cnt           <= 5'd0;
      uncorr        <= 1'b0;
      idx           <= 5'd0;
      out_msg       <= 75'd0;
      out_err_mask  <= 25'd0;
      out_err_count <= 5'd0;
      out_uncorr    <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) cw_reg <= in_codewords;
        end
        CALC: begin
          for (int i = 0; i < CELLS; i++) begin
            err_reg[i] <= calc_s[i][7];
            r_reg[i]   <= calc_s[i][6:3];
            q_reg[i]   <= calc_s[i][2:0];
          end
          cnt    <= pop_s;
          uncorr <= (pop_s > 5'(MAX_CORR));
          idx    <= 5'd0;
        end
        CORR: begin
          q_reg <= q_upd_s;
          idx   <= idx + 5'd1;
          // Last cell: publish including its own correction this cycle.
          if (idx == 5'(CELLS - 1)) begin
            out_msg       <= q_upd_s;
            out_err_mask  <= err_reg;
            out_err_count <= cnt;
            out_uncorr    <= uncorr;
            out_valid     <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n13_array_corr_scheduler.sv
module tb_n13_array_corr_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [149:0] in_codewords = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [74:0]  out_msg;
  logic [24:0]  out_err_mask;
  logic [4:0]   out_err_count;
  logic         out_uncorr;
  logic         out_valid;
  logic         out_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [74:0] msg;
    logic [24:0] mask;
    logic [4:0]  cnt;
    logic        uncorr;
  } exp_t;

  exp_t sb[$];

  n13_array_corr_scheduler dut (
    .clk(clk), .rst(rst), .in_codewords(in_codewords), .in_valid(in_valid),
    .in_ready(in_ready), .out_msg(out_msg), .out_err_mask(out_err_mask),
    .out_err_count(out_err_count), .out_uncorr(out_uncorr),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Reference: plain division, brute-force nearest codeword by Hamming distance.
  function automatic exp_t model(input logic [149:0] blk);
    exp_t e;
    int n;
    logic [5:0] cw, t;
    int m;
    e.msg = '0; e.mask = '0; n = 0;
    for (int i = 0; i < 25; i++) begin
      cw = blk[6*i +: 6];
      if ((int'(cw) % 13) != 0) begin e.mask[i] = 1'b1; n++; end
    end
    e.cnt = 5'(n);
    e.uncorr = (n > 4);
    for (int i = 0; i < 25; i++) begin
      cw = blk[6*i +: 6];
      m = int'(cw) / 13;
      if (e.mask[i] && !e.uncorr)
        for (int k = 0; k < 5; k++) begin
          t = 6'(13 * k);
          if ($countones(t ^ cw) == 1) m = k;
        end
      e.msg[3*i +: 3] = 3'(m);
    end
    return e;
  endfunction

  function automatic logic [149:0] fill(input logic [5:0] v);
    logic [149:0] b;
    for (int i = 0; i < 25; i++) b[6*i +: 6] = v;
    return b;
  endfunction

  task automatic start_block(input string name, input logic [149:0] blk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL %s in_ready before send: got %b want 1", name, in_ready);
    end
    sb.push_back(model(blk));
    in_codewords = blk;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    tests++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL %s timeout: out_valid never rose within %0d clk", name, lat);
    end
  endtask

  task automatic check_out(input string name);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++; $display("FAIL %s scoreboard empty at output", name);
      return;
    end
    e = sb.pop_front();
    if (out_msg !== e.msg || out_err_mask !== e.mask || out_err_count !== e.cnt
        || out_uncorr !== e.uncorr) begin
      fails++;
      $display("FAIL %s result: got msg=%h mask=%h cnt=%0d unc=%b want msg=%h mask=%h cnt=%0d unc=%b",
               name, out_msg, out_err_mask, out_err_count, out_uncorr,
               e.msg, e.mask, e.cnt, e.uncorr);
    end
  endtask

  task automatic ack(input string name);
    logic [74:0] held;
    held = out_msg;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_msg !== held) begin
      fails++;
      $display("FAIL %s after ack: got out_valid=%b in_ready=%b msg=%h want 0 1 %h",
               name, out_valid, in_ready, out_msg, held);
    end
  endtask

  task automatic run_block(input string name, input logic [149:0] blk);
    int lat;
    start_block(name, blk);
    wait_out(name, lat);
    tests++;
    if (lat !== 26) begin
      fails++; $display("FAIL %s latency: got %0d want 26", name, lat);
    end
    check_out(name);
    ack(name);
  endtask

  function automatic logic [149:0] t2_blk();
    logic [149:0] b;
    b = fill(6'd0);
    b[6*7 +: 6] = 6'd40;
    return b;
  endfunction

  function automatic logic [149:0] t3_blk();
    logic [149:0] b;
    b = fill(6'd13);
    b[0 +: 6] = 6'd25;
    b[6*12 +: 6] = 6'd53;
    b[6*24 +: 6] = 6'd30;
    return b;
  endfunction

  task automatic test_reset();
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || out_msg !== 75'd0 || out_err_mask !== 25'd0
        || out_err_count !== 5'd0 || out_uncorr !== 1'b0) begin
      fails++;
      $display("FAIL reset outputs: got v=%b msg=%h mask=%h cnt=%0d unc=%b want all 0",
               out_valid, out_msg, out_err_mask, out_err_count, out_uncorr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_no_errors();
    logic [149:0] b;
    for (int i = 0; i < 25; i++) b[6*i +: 6] = 6'(13 * (i % 5));
    run_block("t1_no_errors", b);
  endtask

  task automatic test_single_error();
    exp_t e;
    e = model(t2_blk());
    tests++;
    if (e.msg[21 +: 3] !== 3'd3 || e.mask !== 25'h80) begin
      fails++; $display("FAIL t2_model_sanity got msg7=%0d mask=%h want 3 80", e.msg[21 +: 3], e.mask);
    end
    run_block("t2_single_error", t2_blk());
  endtask

  task automatic test_multi_error();
    run_block("t3_multi_error", t3_blk());
  endtask

  task automatic test_max_corr();
    logic [149:0] b;
    b = fill(6'd0);
    for (int i = 0; i < 4; i++) b[6*i +: 6] = 6'd25;
    run_block("t4_four_errors", b);
    b[6*4 +: 6] = 6'd25;
    run_block("t4_five_uncorr", b);
  endtask

  task automatic test_backpressure();
    int lat;
    exp_t e;
    start_block("t5_backpressure", t2_blk());
    wait_out("t5_backpressure", lat);
    e = sb[0];
    for (int c = 0; c < 10; c++) begin
      in_codewords = t3_blk();
      in_valid = (c % 2 == 0);
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_msg !== e.msg) begin
        fails++;
        $display("FAIL t5_hold cycle %0d: got v=%b in_ready=%b msg=%h want 1 0 %h",
                 c, out_valid, in_ready, out_msg, e.msg);
      end
    end
    in_valid = 1'b0;
    check_out("t5_backpressure");
    ack("t5_backpressure");
    repeat (30) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL t5_not_taken: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_block();
    start_block("t6_abort", t3_blk());
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    void'(sb.pop_front());
    tests++;
    if (out_valid !== 1'b0 || out_msg !== 75'd0 || out_err_mask !== 25'd0
        || out_err_count !== 5'd0 || out_uncorr !== 1'b0) begin
      fails++;
      $display("FAIL t6_reset_outputs: got v=%b msg=%h mask=%h cnt=%0d unc=%b want all 0",
               out_valid, out_msg, out_err_mask, out_err_count, out_uncorr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL t6_after_release: got in_ready=%b v=%b want 1 0", in_ready, out_valid);
    end
    run_block("t6_then_t2", t2_blk());
  endtask

  initial begin
    test_reset();
    test_no_errors();
    test_single_error();
    test_multi_error();
    test_max_corr();
    test_backpressure();
    test_reset_mid_block();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
